// File: rtl/grad_sq_sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : grad_sq_sum_pkg
//  Purpose  : Widths and latency shared by the gradient magnitude-squared
//             block, its downstream square-root stage and their benches.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package grad_sq_sum_pkg;

  // Signed gradient component width.
  localparam int GRAD_W      = 8;
  // Magnitude-squared word width consumed by the square-root stage.
  localparam int SQ_W        = 16;
  // Input-valid to output-valid latency in clocks.
  localparam int GRAD_SQ_LAT = 3;
  // Saturation counter width.
  localparam int CNT_W       = 16;

endpackage : grad_sq_sum_pkg
`default_nettype wire

// File: rtl/grad_sq_sum_sq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sq_unit
//  Purpose  : Registered signed squarer. Squares a two's complement operand
//             and stores the (always non-negative) result as unsigned.
//  Ports    : clk    in   1        system clock
//             rst_n  in   1        synchronous reset, active low
//             en     in   1        load enable (stage valid)
//             a      in   IN_W     signed operand
//             sq     out  2*IN_W   registered a*a, unsigned
//  Revision : 1.0  initial release
// ============================================================================
module sq_unit #(
  parameter int IN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [IN_W-1:0]        a,
  output logic [2*IN_W-1:0]      sq
);

  logic signed [2*IN_W-1:0] w_a_ext;
  logic signed [2*IN_W-1:0] w_prod;

  // Sign-extend to full product width first; the largest square,
  // (-2^(IN_W-1))^2 = 2^(2*IN_W-2), still fits as a positive value.
  assign w_a_ext = $signed({{IN_W{a[IN_W-1]}}, a});
  assign w_prod  = w_a_ext * w_a_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq <= '0;
    end else if (en) begin
      sq <= w_prod;
    end
  end

endmodule : sq_unit
`default_nettype wire

// File: rtl/grad_sq_sum.sv
`default_nettype none
// ============================================================================
//  Module   : grad_sq_sum
//  Purpose  : 3-stage streaming pipeline computing sat((gx^2+gy^2)>>SHIFT)
//             for the square-root stage, with a saturation flag and a
//             sticky-at-max saturation counter for debug.
//  Ports    : clk        in   1      system clock
//             rst_n      in   1      synchronous reset, active low
//             gx_i       in   IN_W   signed horizontal gradient
//             gy_i       in   IN_W   signed vertical gradient
//             val_i      in   1      gx_i/gy_i valid
//             cnt_clr_i  in   1      synchronous clear of sat_cnt_o
//             sq_sum_o   out  OUT_W  saturated shifted sum of squares
//             sat_o      out  1      sq_sum_o was clipped (with val_o)
//             val_o      out  1      sq_sum_o/sat_o valid
//             sat_cnt_o  out  16     saturated valid samples, sticks at max
//  Revision : 1.0  initial release
// ============================================================================
module grad_sq_sum
  import grad_sq_sum_pkg::*;
#(
  parameter int IN_W  = GRAD_W,
  parameter int OUT_W = SQ_W,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   gx_i,
  input  logic [IN_W-1:0]   gy_i,
  input  logic              val_i,
  input  logic              cnt_clr_i,
  output logic [OUT_W-1:0]  sq_sum_o,
  output logic              sat_o,
  output logic              val_o,
  output logic [CNT_W-1:0]  sat_cnt_o
);

  localparam int SQ_IW = 2 * IN_W;
  localparam int SUM_W = 2 * IN_W + 1;

  // Valid shift register: r_val1 = S1, r_val2 = S2, val_o = S3.
  logic              r_val1;
  logic              r_val2;

  logic [IN_W-1:0]   r_gx;
  logic [IN_W-1:0]   r_gy;
  logic [SQ_IW-1:0]  w_sq_x;
  logic [SQ_IW-1:0]  w_sq_y;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_shifted;
  logic [OUT_W-1:0]  w_res;
  logic              w_over;

  // ---------------- S1: register inputs ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val1 <= 1'b0;
      r_val2 <= 1'b0;
      val_o  <= 1'b0;
      r_gx   <= '0;
      r_gy   <= '0;
    end else begin
      r_val1 <= val_i;
      r_val2 <= r_val1;
      val_o  <= r_val2;
      if (val_i) begin
        r_gx <= gx_i;
        r_gy <= gy_i;
      end
    end
  end

  // ---------------- S2: square each component ----------------
  sq_unit #(.IN_W(IN_W)) u_sq_x (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_val1),
    .a     (r_gx),
    .sq    (w_sq_x)
  );

  sq_unit #(.IN_W(IN_W)) u_sq_y (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_val1),
    .a     (r_gy),
    .sq    (w_sq_y)
  );

  // ---------------- S3: add, shift, saturate ----------------
  assign w_sum     = {1'b0, w_sq_x} + {1'b0, w_sq_y};
  assign w_shifted = w_sum >> SHIFT;

  generate
    if (OUT_W < SUM_W) begin : g_sat
      // Any set bit above the output width means the value exceeds max.
      assign w_over = |w_shifted[SUM_W-1:OUT_W];
      assign w_res  = w_over ? {OUT_W{1'b1}} : w_shifted[OUT_W-1:0];
    end else begin : g_nosat
      // Output wide enough for any sum: clipping is impossible.
      assign w_over = 1'b0;
      assign w_res  = OUT_W'(w_shifted);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_sum_o <= '0;
      sat_o    <= 1'b0;
    end else if (r_val2) begin
      sq_sum_o <= w_res;
      sat_o    <= w_over;
    end
  end

  // Counter updates on the same edge that presents the saturated result, so
  // sat_cnt_o already includes a sample while that sample is on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      sat_cnt_o <= '0;
    end else if (r_val2 && w_over && (sat_cnt_o != {CNT_W{1'b1}})) begin
      sat_cnt_o <= sat_cnt_o + 1'b1;
    end
  end

endmodule : grad_sq_sum
`default_nettype wire

// File: tb/tb_grad_sq_sum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grad_sq_sum
//  Purpose  : Directed self-checking bench for grad_sq_sum. Three instances
//             share one stimulus: default widths, a 15-bit output to force
//             saturation, and SHIFT=2 to exercise truncation.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_grad_sq_sum;
  import grad_sq_sum_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [7:0]        gx;
  logic [7:0]        gy;
  logic              val_i;
  logic              cnt_clr;

  logic [15:0]       sq_a;
  logic              sat_a, val_a;
  logic [15:0]       cnt_a;
  logic [14:0]       sq_b;
  logic              sat_b, val_b;
  logic [15:0]       cnt_b;
  logic [15:0]       sq_c;
  logic              sat_c, val_c;
  logic [15:0]       cnt_c;

  int checks   = 0;
  int failures = 0;

  grad_sq_sum #(.IN_W(8), .OUT_W(16), .SHIFT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .gx_i(gx), .gy_i(gy), .val_i(val_i),
    .cnt_clr_i(cnt_clr), .sq_sum_o(sq_a), .sat_o(sat_a), .val_o(val_a),
    .sat_cnt_o(cnt_a)
  );

  grad_sq_sum #(.IN_W(8), .OUT_W(15), .SHIFT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .gx_i(gx), .gy_i(gy), .val_i(val_i),
    .cnt_clr_i(cnt_clr), .sq_sum_o(sq_b), .sat_o(sat_b), .val_o(val_b),
    .sat_cnt_o(cnt_b)
  );

  grad_sq_sum #(.IN_W(8), .OUT_W(16), .SHIFT(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .gx_i(gx), .gy_i(gy), .val_i(val_i),
    .cnt_clr_i(cnt_clr), .sq_sum_o(sq_c), .sat_o(sat_c), .val_o(val_c),
    .sat_cnt_o(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y);
    val_i = v;
    gx    = 8'(x);
    gy    = 8'(y);
  endtask

  // Single-sample pulse; returns when that sample is on the outputs.
  task automatic send(input int x, input int y);
    drive(1'b1, x, y);
    tick();
    drive(1'b0, 0, 0);
    repeat (GRAD_SQ_LAT - 1) tick();
  endtask

  int pv [5] = '{1, 0, 1, 1, 0};
  int px [5] = '{1, 100, 2, 5, 100};
  int py [5] = '{2, 100, 3, 5, 100};
  int last_sq;
  int exp_v;

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, 0, 0);
    tick(); tick();
    check("rst_sq",  32'(sq_a),  0);
    check("rst_val", 32'(val_a), 0);
    check("rst_sat", 32'(sat_a), 0);
    check("rst_cnt", 32'(cnt_b), 0);
    rst_n = 1'b1;

    // Latency: 3,4 -> 25 appears exactly three edges later.
    drive(1'b1, 3, 4); tick(); drive(1'b0, 0, 0);
    check("lat_e1_val", 32'(val_a), 0);
    tick();
    check("lat_e2_val", 32'(val_a), 0);
    tick();
    check("t1_val",    32'(val_a), 1);
    check("t1_sq",     32'(sq_a),  25);
    check("t1_sat",    32'(sat_a), 0);
    check("t1_sh2_sq", 32'(sq_c),  6);
    tick();
    check("t1_val_drop", 32'(val_a), 0);
    check("t1_hold",     32'(sq_a),  25);

    // Most negative inputs.
    send(-128, -128);
    check("neg_a_sq",  32'(sq_a),  32768);
    check("neg_a_sat", 32'(sat_a), 0);
    check("neg_b_sq",  32'(sq_b),  32767);
    check("neg_b_sat", 32'(sat_b), 1);
    check("neg_b_cnt", 32'(cnt_b), 1);
    check("neg_a_cnt", 32'(cnt_a), 0);
    check("neg_c_sq",  32'(sq_c),  8192);

    // Shift truncation.
    send(10, 0);
    check("sh_10_0_c", 32'(sq_c), 25);
    check("sh_10_0_a", 32'(sq_a), 100);
    send(1, 1);
    check("sh_1_1_c",  32'(sq_c),  0);
    check("sh_1_1_a",  32'(sq_a),  2);
    check("sh_1_1_bs", 32'(sat_b), 0);
    check("sh_1_1_bc", 32'(cnt_b), 1);

    // Bubble pattern 1,0,1,1,0; bubble data is junk and must not load.
    last_sq = 2;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(pv[i][0], px[i], py[i]);
      else       drive(1'b0, 0, 0);
      tick();
      if (i >= 2) begin
        exp_v = pv[i-2];
        if (exp_v != 0) last_sq = px[i-2] * px[i-2] + py[i-2] * py[i-2];
        check("pat_val", 32'(val_a), 32'(exp_v));
        check("pat_sq",  32'(sq_a),  32'(last_sq));
      end
    end

    // Reset with samples in flight.
    drive(1'b1, 7, 7); tick();
    drive(1'b1, 8, 8); tick();
    drive(1'b1, 9, 9); rst_n = 1'b0; tick();
    rst_n = 1'b1; drive(1'b0, 0, 0);
    check("mrst_val", 32'(val_a), 0);
    check("mrst_sq",  32'(sq_a),  0);
    check("mrst_cnt", 32'(cnt_b), 0);
    check("mrst_sat", 32'(sat_b), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_val", 32'(val_a), 0);
    end
    drive(1'b1, 6, 8); tick(); drive(1'b0, 0, 0);
    check("post_e1_val", 32'(val_a), 0);
    tick();
    check("post_e2_val", 32'(val_a), 0);
    tick();
    check("post_val", 32'(val_a), 1);
    check("post_sq",  32'(sq_a),  100);

    // Counter accumulation and clear coinciding with a saturated sample.
    send(-128, -128);
    check("cnt_1", 32'(cnt_b), 1);
    send(-128, -128);
    check("cnt_2", 32'(cnt_b), 2);
    drive(1'b1, -128, -128); tick(); drive(1'b0, 0, 0);
    tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_sat", 32'(sat_b), 1);
    check("clr_sq",  32'(sq_b),  32767);
    check("clr_cnt", 32'(cnt_b), 0);
    tick();
    check("clr_hold", 32'(cnt_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_grad_sq_sum
`default_nettype wire
